// File: rtl/store_mon_pkg.sv
// Shared types and constants for the store-bus run monitor.
package store_mon_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ADDR    = 2'd1;
    localparam logic [1:0] FC_DATA    = 2'd2;
    localparam logic [1:0] FC_TIMEOUT = 2'd3;

    localparam int STORE_CNT_W = 16;
    localparam int CYC_W       = 32;

endpackage

// File: rtl/store_monitor_if.sv
// Store-bus and status bundle between the CPU side (master) and the monitor (slave).
interface store_monitor_if
    import store_mon_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TRACE_DEPTH = 8
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = $clog2(TRACE_DEPTH);

    logic [BE_W-1:0]        wr_be;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic                   done;
    logic                   pass;
    logic [1:0]             fail_code;
    logic [STORE_CNT_W-1:0] store_cnt;
    logic [ADDR_W-1:0]      fail_addr;
    logic [DATA_W-1:0]      fail_data;
    logic [IDX_W-1:0]       trace_rd_idx;
    logic [ADDR_W-1:0]      trace_rd_addr;
    logic [DATA_W-1:0]      trace_rd_data;
    logic [IDX_W:0]         trace_count;

    modport master (
        output wr_be, wr_addr, wr_data, trace_rd_idx,
        input  done, pass, fail_code, store_cnt, fail_addr, fail_data,
        input  trace_rd_addr, trace_rd_data, trace_count
    );

    modport slave (
        input  wr_be, wr_addr, wr_data, trace_rd_idx,
        output done, pass, fail_code, store_cnt, fail_addr, fail_data,
        output trace_rd_addr, trace_rd_data, trace_count
    );

endinterface

// File: rtl/store_trace_buf.sv
// Circular trace of recent stores; index 0 reads the newest entry, unfilled slots read 0.
module store_trace_buf #(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 8,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [IDX_W:0]    count_o
);
    localparam logic [IDX_W:0] FULL = (IDX_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [IDX_W-1:0]  wrptr_q, wrptr_d;
    logic [IDX_W:0]    count_q, count_d;
    logic [IDX_W-1:0]  rd_ptr;
    logic              rd_valid;

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        wrptr_d = wrptr_q;
        count_d = count_q;
        if (we_i) begin
            wrptr_d = wrptr_q + IDX_W'(1);
            if (count_q != FULL) count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr_q <= '0;
            count_q <= '0;
        end else begin
            wrptr_q <= wrptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array has no reset; count_q gates every read, so stale entries never escape.
    always_ff @(posedge clk) begin
        if (we_i) begin
            addr_mem_q[wrptr_q] <= addr_i;
            data_mem_q[wrptr_q] <= data_i;
        end
    end

    // Power-of-two depth lets the pointer arithmetic wrap for free.
    assign rd_ptr    = wrptr_q - IDX_W'(1) - rd_idx_i;
    assign rd_valid  = {1'b0, rd_idx_i} < count_q;
    assign rd_addr_o = rd_valid ? addr_mem_q[rd_ptr] : '0;
    assign rd_data_o = rd_valid ? data_mem_q[rd_ptr] : '0;
    assign count_o   = count_q;

endmodule

// File: rtl/store_monitor.sv
// Store-bus run checker: classifies the run as PASS/FAIL/TIMEOUT and latches diagnostics.
// Define STORE_MON_TRACE_EN to build the circular trace of recent stores.
module store_monitor
    import store_mon_pkg::*;
#(
    parameter int              DATA_W        = 32,
    parameter int              ADDR_W        = 32,
    parameter logic [ADDR_W-1:0] PASS_ADDR   = ADDR_W'(84),
    parameter logic [DATA_W-1:0] PASS_DATA   = DATA_W'(7),
    parameter logic [ADDR_W-1:0] SCRATCH_ADDR = ADDR_W'(80),
    parameter int unsigned     SCRATCH_BYTES = 4,
    parameter int unsigned     TIMEOUT_CYC   = 100000,
    parameter int              TRACE_DEPTH   = 8
) (
    input logic clk,
    input logic rst,
    store_monitor_if.slave bus
);
    localparam int               BE_W       = DATA_W / 8;
    localparam logic [ADDR_W:0]  WIN_LO     = {1'b0, SCRATCH_ADDR};
    localparam logic [ADDR_W:0]  WIN_HI     = WIN_LO + (ADDR_W + 1)'(SCRATCH_BYTES);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYC != 0);
    localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(TIMEOUT_CYC - 1);

    state_e                 state_q, state_d;
    logic [CYC_W-1:0]       cyc_q, cyc_d;
    logic [STORE_CNT_W-1:0] store_cnt_q, store_cnt_d;
    logic [1:0]             fail_code_q, fail_code_d;
    logic [ADDR_W-1:0]      fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0]      fail_data_q, fail_data_d;

    logic is_store, run_store, full_be, in_window;

    assign is_store  = |bus.wr_be;
    assign run_store = is_store && (state_q == ST_RUN);
    assign full_be   = &bus.wr_be;
    // One extra bit keeps the window end from wrapping near the top of the address space.
    assign in_window = ({1'b0, bus.wr_addr} >= WIN_LO) && ({1'b0, bus.wr_addr} < WIN_HI);

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        store_cnt_d = store_cnt_q;
        fail_code_d = fail_code_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;

        if (state_q == ST_RUN) begin
            if (cyc_q != '1) cyc_d = cyc_q + 1'b1;

            if (is_store) begin
                if (store_cnt_q != '1) store_cnt_d = store_cnt_q + 1'b1;
                if (bus.wr_addr == PASS_ADDR) begin
                    if (full_be && (bus.wr_data == PASS_DATA)) begin
                        state_d = ST_PASS;
                    end else begin
                        state_d     = ST_FAIL;
                        fail_code_d = FC_DATA;
                        fail_addr_d = bus.wr_addr;
                        fail_data_d = bus.wr_data;
                    end
                end else if (!in_window) begin
                    state_d     = ST_FAIL;
                    fail_code_d = FC_ADDR;
                    fail_addr_d = bus.wr_addr;
                    fail_data_d = bus.wr_data;
                end
            end

            // A store wins over timeout; timeout only fires if the run is still open.
            if (TIMEOUT_EN && (state_d == ST_RUN) && (cyc_q == CYC_LAST)) begin
                state_d     = ST_TIMEOUT;
                fail_code_d = FC_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cyc_q       <= '0;
            store_cnt_q <= '0;
            fail_code_q <= FC_NONE;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            store_cnt_q <= store_cnt_d;
            fail_code_q <= fail_code_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign bus.done      = (state_q != ST_RUN);
    assign bus.pass      = (state_q == ST_PASS);
    assign bus.fail_code = fail_code_q;
    assign bus.store_cnt = store_cnt_q;
    assign bus.fail_addr = fail_addr_q;
    assign bus.fail_data = fail_data_q;

`ifdef STORE_MON_TRACE_EN
    store_trace_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (TRACE_DEPTH)
    ) u_trace (
        .clk       (clk),
        .rst       (rst),
        .we_i      (run_store),
        .addr_i    (bus.wr_addr),
        .data_i    (bus.wr_data),
        .rd_idx_i  (bus.trace_rd_idx),
        .rd_addr_o (bus.trace_rd_addr),
        .rd_data_o (bus.trace_rd_data),
        .count_o   (bus.trace_count)
    );
`else
    logic [$clog2(TRACE_DEPTH)-1:0] unused_idx;
    logic                           unused_run_store;
    logic [BE_W-1:0]                unused_be;

    assign unused_idx        = bus.trace_rd_idx;
    assign unused_run_store  = run_store;
    assign unused_be         = bus.wr_be;
    assign bus.trace_rd_addr = '0;
    assign bus.trace_rd_data = '0;
    assign bus.trace_count   = '0;
`endif

endmodule

// File: tb/tb_store_monitor.sv
// Scoreboard bench for store_monitor: directed test-plan cases plus randomized runs vs a queue-based model.
module tb_store_monitor;
    import store_mon_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TO    = 50;
    localparam int PA    = 84;
    localparam int PD    = 7;
    localparam int SA    = 80;
    localparam int SB    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    store_monitor_if #(.ADDR_W(AW), .DATA_W(DW), .TRACE_DEPTH(DEPTH)) bus ();

    store_monitor #(
        .DATA_W        (DW),
        .ADDR_W        (AW),
        .PASS_ADDR     (AW'(PA)),
        .PASS_DATA     (DW'(PD)),
        .SCRATCH_ADDR  (AW'(SA)),
        .SCRATCH_BYTES (SB),
        .TIMEOUT_CYC   (TO),
        .TRACE_DEPTH   (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
    typedef struct {
        bit done; bit pass; int code; int cnt;
        logic [31:0] faddr; logic [31:0] fdata;
        int tcount; logic [31:0] taddr; logic [31:0] tdata;
    } exp_t;

    ent_t        m_trace [$];
    bit          m_done, m_pass;
    int          m_code, m_cnt, m_run_edges;
    logic [31:0] m_faddr, m_fdata;
    exp_t        exp_q [$];

    task automatic model_fail(int code, logic [31:0] a, logic [31:0] d);
        m_done  = 1; m_code = code; m_faddr = a; m_fdata = d;
    endtask

    task automatic model_edge(bit r, logic [3:0] be, logic [31:0] a, logic [31:0] d);
        longint addr;
        if (r) begin
            m_done = 0; m_pass = 0; m_code = 0; m_cnt = 0; m_run_edges = 0;
            m_faddr = 0; m_fdata = 0;
            m_trace.delete();
            return;
        end
        if (m_done) return;
        m_run_edges++;
        if (be != 0) begin
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            m_trace.push_front('{a: a, d: d});
            if (m_trace.size() > DEPTH) void'(m_trace.pop_back());
            addr = longint'(a);
            if (addr == PA) begin
                if (be == 4'hF && d == PD) begin m_done = 1; m_pass = 1; end
                else model_fail(2, a, d);
            end else if (!(addr >= SA && addr < SA + SB)) begin
                model_fail(1, a, d);
            end
        end
        if (!m_done && TO != 0 && m_run_edges == TO) begin
            m_done = 1; m_code = 3;
        end
    endtask

    function automatic exp_t predict(int idx);
        exp_t e;
        e.done = m_done; e.pass = m_pass; e.code = m_code; e.cnt = m_cnt;
        e.faddr = m_faddr; e.fdata = m_fdata;
        e.tcount = 0; e.taddr = 0; e.tdata = 0;
`ifdef STORE_MON_TRACE_EN
        e.tcount = m_trace.size();
        if (idx < m_trace.size()) begin
            e.taddr = m_trace[idx].a;
            e.tdata = m_trace[idx].d;
        end
`endif
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic step(bit r, logic [3:0] be, logic [31:0] a, logic [31:0] d, int idx);
        rst              = r;
        bus.wr_be        = be;
        bus.wr_addr      = a;
        bus.wr_data      = d;
        bus.trace_rd_idx = IDX_W'(idx);
        @(posedge clk);
        #1;
        model_edge(r, be, a, d);
        exp_q.push_back(predict(idx));
        @(negedge clk);
        #1;
    endtask

    task automatic idle(int idx);
        step(1'b0, 4'h0, $urandom, $urandom, idx);
    endtask

    task automatic do_reset(int cycles);
        repeat (cycles) step(1'b1, 4'h0, 32'h0, 32'h0, 0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("done",       64'(bus.done),          64'(e.done));
                check("pass",       64'(bus.pass),          64'(e.pass));
                check("fail_code",  64'(bus.fail_code),     64'(e.code));
                check("store_cnt",  64'(bus.store_cnt),     64'(e.cnt));
                check("fail_addr",  64'(bus.fail_addr),     64'(e.faddr));
                check("fail_data",  64'(bus.fail_data),     64'(e.fdata));
                check("trace_cnt",  64'(bus.trace_count),   64'(e.tcount));
                check("trace_addr", 64'(bus.trace_rd_addr), 64'(e.taddr));
                check("trace_data", 64'(bus.trace_rd_data), 64'(e.tdata));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=running required=finished at %0t", $time);
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.wr_be = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.trace_rd_idx = '0;
        @(negedge clk);
        #1;

        // Scratch store then the passing store.
        do_reset(10);
        check("rst_done", 64'(bus.done), 64'd0);
        step(1'b0, 4'hF, 32'd80, 32'd2, 0);
        step(1'b0, 4'hF, 32'd84, 32'd7, 0);
        check("t1_pass", 64'(bus.pass), 64'd1);
        check("t1_done", 64'(bus.done), 64'd1);
        check("t1_code", 64'(bus.fail_code), 64'd0);
        check("t1_cnt",  64'(bus.store_cnt), 64'd2);
`ifdef STORE_MON_TRACE_EN
        check("t1_idx0_a", 64'(bus.trace_rd_addr), 64'd84);
        check("t1_idx0_d", 64'(bus.trace_rd_data), 64'd7);
        idle(1);
        check("t1_idx1_a", 64'(bus.trace_rd_addr), 64'd80);
        check("t1_idx1_d", 64'(bus.trace_rd_data), 64'd2);
`else
        idle(1);
        check("t1_notrace", 64'(bus.trace_rd_data), 64'd0);
`endif

        // Wrong data at the pass address, then a late correct store is ignored.
        do_reset(1);
        step(1'b0, 4'hF, 32'd84, 32'd5, 0);
        check("t2_code",  64'(bus.fail_code), 64'd2);
        check("t2_faddr", 64'(bus.fail_addr), 64'd84);
        check("t2_fdata", 64'(bus.fail_data), 64'd5);
        step(1'b0, 4'hF, 32'd84, 32'd7, 0);
        check("t2_hold_pass",  64'(bus.pass),      64'd0);
        check("t2_hold_fdata", 64'(bus.fail_data), 64'd5);
        check("t2_hold_cnt",   64'(bus.store_cnt), 64'd1);

        // Partial byte-enable at the pass address.
        do_reset(1);
        step(1'b0, 4'h1, 32'd84, 32'd7, 0);
        check("t3_code", 64'(bus.fail_code), 64'd2);

        // Window edges, then an out-of-window store.
        do_reset(1);
        step(1'b0, 4'hF, 32'd80, $urandom, 0);
        step(1'b0, 4'h2, 32'd83, $urandom, 0);
        check("t4_run", 64'(bus.done),      64'd0);
        check("t4_cnt", 64'(bus.store_cnt), 64'd2);
        step(1'b0, 4'hF, 32'd100, 32'd1, 0);
        check("t4_code",  64'(bus.fail_code), 64'd1);
        check("t4_faddr", 64'(bus.fail_addr), 64'd100);

        // Timeout exactly TO cycles after reset, then a one-cycle reset restarts.
        do_reset(1);
        repeat (TO - 1) idle(0);
        check("t5_before", 64'(bus.done), 64'd0);
        idle(0);
        check("t5_done", 64'(bus.done),      64'd1);
        check("t5_code", 64'(bus.fail_code), 64'd3);
        do_reset(1);
        check("t5_rst_done", 64'(bus.done),        64'd0);
        check("t5_rst_code", 64'(bus.fail_code),   64'd0);
        check("t5_rst_cnt",  64'(bus.store_cnt),   64'd0);
        check("t5_rst_tcnt", 64'(bus.trace_count), 64'd0);
        idle(0);
        check("t5_resume", 64'(bus.done), 64'd0);

        // Store on the timeout cycle: a passing store wins, a scratch store does not.
        do_reset(1);
        repeat (TO - 1) idle(0);
        step(1'b0, 4'hF, 32'd84, 32'd7, 0);
        check("t5_store_pass", 64'(bus.pass), 64'd1);
        do_reset(1);
        repeat (TO - 1) idle(0);
        step(1'b0, 4'hF, 32'd81, 32'd9, 0);
        check("t5_store_to", 64'(bus.fail_code), 64'd3);

        // Trace wrap-around.
        do_reset(1);
        for (int i = 1; i <= 10; i++) step(1'b0, 4'hF, 32'd80, 32'(i), 0);
`ifdef STORE_MON_TRACE_EN
        check("t6_tcnt", 64'(bus.trace_count),   64'd8);
        check("t6_idx0", 64'(bus.trace_rd_data), 64'd10);
        idle(7);
        check("t6_idx7", 64'(bus.trace_rd_data), 64'd3);
`else
        check("t6_tcnt", 64'(bus.trace_count), 64'd0);
        idle(7);
`endif

        // Randomized runs.
        for (int ep = 0; ep < 40; ep++) begin
            int len;
            do_reset(1);
            len = $urandom_range(5, 60);
            for (int i = 0; i < len; i++) begin
                logic [31:0] a, d;
                logic [3:0]  be;
                int          idx;
                idx = $urandom_range(0, DEPTH - 1);
                if ($urandom_range(0, 99) < 2) begin
                    step(1'b1, 4'h0, 32'h0, 32'h0, idx);
                end else if ($urandom_range(0, 99) < 40) begin
                    idle(idx);
                end else begin
                    case ($urandom_range(0, 7))
                        0, 1, 2, 3: a = 32'(SA + $urandom_range(0, SB - 1));
                        4:          a = 32'(PA);
                        5:          a = 32'(SA - 1);
                        6:          a = 32'(PA + 1);
                        default:    a = $urandom;
                    endcase
                    be = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(1, 15));
                    d  = ($urandom_range(0, 1) != 0) ? 32'(PD) : $urandom;
                    step(1'b0, be, a, d, idx);
                end
            end
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_monitor.md
Name: store_monitor

Overview:
Synthesizable store-bus checker for the CPU's data-memory write port. It replaces the ad-hoc negedge pass/fail check done in simulation benches. It watches every store (any byte-enable set) and classifies the run as PASS, FAIL or TIMEOUT using parametrised pass address/data and an allowed scratch window. It latches diagnostic state and optionally keeps a circular trace of recent stores, so the same block works in simulation and on the FPGA (status to LEDs/UART).

Parameters:
DATA_W, 32, store data width; must be a multiple of 8
ADDR_W, 32, store address width
BE_W, DATA_W/8, byte-enable width (derived, not overridable)
PASS_ADDR, 84, address whose correct store ends the run as PASS
PASS_DATA, 7, full-word value required at PASS_ADDR
SCRATCH_ADDR, 80, base of the byte window where stores are permitted
SCRATCH_BYTES, 4, size of the permitted window in bytes
TIMEOUT_CYC, 100000, RUN cycles allowed before TIMEOUT; 0 disables the timeout
TRACE_DEPTH, 8, trace entries; must be a power of two and at least 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
wr_be  in  BE_W  store byte enables; a store is any nonzero value
wr_addr  in  ADDR_W  store byte address
wr_data  in  DATA_W  store data
done  out  1  sticky; high in any terminal state
pass  out  1  sticky; high only in PASS
fail_code  out  2  0 none, 1 bad address, 2 bad data at PASS_ADDR, 3 timeout
store_cnt  out  16  stores observed in RUN; saturates at 16'hFFFF
fail_addr  out  ADDR_W  wr_addr of the offending store
fail_data  out  DATA_W  wr_data of the offending store
trace_rd_idx  in  log2(TRACE_DEPTH)  0 = newest entry
trace_rd_addr  out  ADDR_W  address of the selected trace entry
trace_rd_data  out  DATA_W  data of the selected trace entry
trace_count  out  log2(TRACE_DEPTH)+1  valid entries; saturates at TRACE_DEPTH

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to RUN.
  - All outputs go to 0; trace_count goes to 0.
  - The cycle counter clears.
  - rst high in any state, including terminal states, restarts the check.
- States: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal and are left only by rst.
- Stores are sampled at the rising edge. Status outputs update in the same edge, so they are visible 1 cycle after the store.
- Store classification in RUN, in priority order:
  - wr_addr == PASS_ADDR, wr_be all ones and wr_data == PASS_DATA → PASS.
  - wr_addr == PASS_ADDR otherwise → FAIL, code 2.
  - wr_addr in [SCRATCH_ADDR, SCRATCH_ADDR+SCRATCH_BYTES) → stay in RUN.
  - Any other address → FAIL, code 1.
- Window compare is unsigned at ADDR_W+1 bits, so the window end cannot wrap.
- On entering FAIL: fail_addr and fail_data latch the offending store and then hold.
- store_cnt increments on every store seen in RUN, including the terminating store. It freezes in terminal states.
- Cycle counter:
  - Counts every cycle spent in RUN.
  - When it reaches TIMEOUT_CYC-1 with no store that cycle → TIMEOUT, code 3.
  - A store and timeout in the same cycle: the store is classified first and timeout applies only if the state stays RUN.
  - The counter is 32 bits wide and saturates.
- Stores in terminal states are ignored: no counting, no trace, no latch update.
- Trace buffer:
  - Every RUN store, including the terminating store, writes {addr, data} at the write pointer, and the pointer increments mod TRACE_DEPTH.
  - Wrap-around overwrites the oldest entry.
  - Read is combinational: entry = (wrptr-1-trace_rd_idx) mod TRACE_DEPTH.
  - Entries with trace_rd_idx ≥ trace_count read as 0.

Optional Feature:
- Macro: STORE_MON_TRACE_EN.
- Defined: the trace buffer is instantiated as described above.
- Undefined:
  - No trace storage is built.
  - trace_rd_addr, trace_rd_data and trace_count are tied to 0.
  - trace_rd_idx is ignored.
  - Pass/fail behaviour is unchanged.

Decomposition:
- Package store_mon_pkg holds:
  - the state enum (RUN, PASS, FAIL, TIMEOUT);
  - the fail_code constants (FC_NONE, FC_ADDR, FC_DATA, FC_TIMEOUT);
  - the store_cnt width constant (16).
- Sub-module store_trace_buf:
  - Parametrised by ADDR_W, DATA_W and DEPTH.
  - Contains the write pointer, count and combinational indexed read.
  - Instantiated only under STORE_MON_TRACE_EN.

Test Plan:
- Reset for 10 cycles, then a full-BE store of 2 at address 80, then a full-BE store of 7 at address 84 → pass=1, done=1, fail_code=0, store_cnt=2; with trace on, idx0 reads (84,7) and idx1 reads (80,2).
- Full-BE store of 5 at address 84 → FAIL, fail_code=2, fail_addr=84, fail_data=5; a later store of 7 at address 84 leaves the status unchanged.
- wr_be=4'b0001 with data 7 at address 84 → FAIL, fail_code=2.
- Store of 1 at address 100 → FAIL, fail_code=1, fail_addr=100; stores at 80 and 83 before it stay in RUN with store_cnt=2.
- Bench built with TIMEOUT_CYC=50 and no stores → done=1, fail_code=3 exactly 50 cycles after rst deasserts; then rst for 1 cycle → all outputs 0 and RUN resumes.
- Trace on, TRACE_DEPTH=8, 10 stores at address 80 with data 1..10 → trace_count=8, idx0 reads data 10, idx7 reads data 3.
